// File: rtl/countdown_timer_pkg.sv
// Shared game package: timer state encoding and status-board digit limits.
// Imported by the countdown timer and its prescaler.
package countdown_timer_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Cycle counter with enable and clear; pulses wrap on its last count.
// Ports: clk, rst (sync, active-high), en, clr -> wrap.
module countdown_timer_tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign wrap = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Game-clock countdown: whole seconds from START_VAL to 0 with pause/bonus.
// Ports: clk, rst, start, pause_tgl, add_time -> id, running, expired,
//        expired_pulse, tick (all registered).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int START_VAL = 10,
  parameter int MAX_VAL   = MAX_DIGIT,
  parameter int ADD_VAL   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause_tgl,
  input  logic               add_time,
  output logic [DIGIT_W-1:0] id,
  output logic               running,
  output logic               expired,
  output logic               expired_pulse,
  output logic               tick
);

  localparam int AW = DIGIT_W + 1;
  localparam logic [AW-1:0] ADD_A = AW'(ADD_VAL);
  localparam logic [AW-1:0] MAX_A = AW'(MAX_VAL);
  localparam logic [DIGIT_W-1:0] START_D = DIGIT_W'(START_VAL);

  state_e state_q, state_d;
  logic [DIGIT_W-1:0] id_q, id_d;
  logic running_q, running_d;
  logic expired_q, expired_d;
  logic pulse_q, pulse_d;
  logic tick_q, tick_d;

  logic          wrap;
  logic          pre_clr;
  logic [AW-1:0] id_ext;
  logic [AW-1:0] id_adj;
  logic          expire_c;

  assign pre_clr = start || (state_q == ST_IDLE) || (state_q == ST_DONE);

  countdown_timer_tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .clr  (pre_clr),
    .wrap (wrap)
  );

  // Tick decrement and bonus fold into one saturating update.
  always_comb begin
    id_ext = {1'b0, id_q} - {{(AW-1){1'b0}}, wrap};
    if (add_time) id_ext = id_ext + ADD_A;
    id_adj = (id_ext > MAX_A) ? MAX_A : id_ext;
  end

  assign expire_c = (state_q == ST_RUN) && !start && wrap
                    && (id_adj == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start)          state_d = ST_RUN;
        else if (expire_c)  state_d = ST_DONE;
        else if (pause_tgl) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (start || pause_tgl) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    id_d      = id_q;
    tick_d    = 1'b0;
    pulse_d   = 1'b0;
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_DONE);
    if (start) begin
      id_d = START_D;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (wrap || add_time) id_d = id_adj[DIGIT_W-1:0];
          tick_d  = wrap;
          pulse_d = expire_c;
        end
        ST_PAUSED: begin
          if (add_time) id_d = id_adj[DIGIT_W-1:0];
        end
        ST_DONE: begin
          id_d = '0;
        end
        default: begin
          id_d = id_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q      <= START_D;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      id_q      <= id_d;
      running_q <= running_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      tick_q    <= tick_d;
    end
  end

  assign id            = id_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;
  assign tick          = tick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (TICK_DIV=4, START=MAX=10, ADD=3).
// Expected outputs are queued per cycle and compared after each edge.
module tb_countdown_timer;

  localparam int TDIV = 4;
  localparam int SVAL = 10;

  typedef struct packed {
    logic [3:0] id;
    logic       run;
    logic       ex;
    logic       pls;
    logic       tck;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause_tgl = 1'b0;
  logic       add_time = 1'b0;
  logic [3:0] id;
  logic       running;
  logic       expired;
  logic       expired_pulse;
  logic       tick;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  countdown_timer #(
    .TICK_DIV  (TDIV),
    .START_VAL (SVAL),
    .MAX_VAL   (10),
    .ADD_VAL   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pause_tgl     (pause_tgl),
    .add_time      (add_time),
    .id            (id),
    .running       (running),
    .expired       (expired),
    .expired_pulse (expired_pulse),
    .tick          (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t outs();
    exp_t o;
    o.id  = id;
    o.run = running;
    o.ex  = expired;
    o.pls = expired_pulse;
    o.tck = tick;
    return o;
  endfunction

  function automatic exp_t mk(int v, bit r, bit x, bit p, bit t);
    exp_t e;
    e.id  = 4'(v);
    e.run = r;
    e.ex  = x;
    e.pls = p;
    e.tck = t;
    return e;
  endfunction

  // Expected outputs c cycles after a start pulse, no other inputs.
  function automatic exp_t exp_run(int c);
    int n;
    n = c / TDIV;
    return mk((n >= SVAL) ? 0 : SVAL - n, n < SVAL, n >= SVAL,
              c == SVAL * TDIV,
              c > 0 && c <= SVAL * TDIV && (c % TDIV) == 0);
  endfunction

  task automatic test_reset();
    exp_t e, got;
    for (int c = 0; c < 4; c++) begin
      rst       = (c == 0);
      start     = (c == 0);
      add_time  = (c == 2);
      pause_tgl = (c == 3);
      sb.push_back(mk(10, 0, 0, 0, 0));
      step();
      {rst, start, add_time, pause_tgl} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset c=%0d got=%b want=%b (id,run,exp,pls,tck)",
                 c, got, e);
      end
    end
  endtask

  task automatic test_countdown();
    exp_t e, got;
    int   nt = 0;
    int   np = 0;
    for (int c = 0; c <= 44; c++) begin
      start = (c == 0);
      sb.push_back(exp_run(c));
      step();
      start = 1'b0;
      got = outs();
      nt += int'(got.tck);
      np += int'(got.pls);
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL countdown c=%0d got=%b want=%b", c, got, e);
      end
    end
    total++;
    if (nt !== 10) begin
      bad++;
      $display("FAIL tick_count got=%0d want=10", nt);
    end
    total++;
    if (np !== 1) begin
      bad++;
      $display("FAIL pulse_count got=%0d want=1", np);
    end
  endtask

  task automatic test_restart_done();
    exp_t e, got;
    for (int c = 0; c <= 2; c++) begin
      add_time  = (c == 0);
      pause_tgl = (c == 1);
      start     = (c == 2);
      sb.push_back((c == 2) ? mk(10, 1, 0, 0, 0) : mk(0, 0, 1, 0, 0));
      step();
      {start, add_time, pause_tgl} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL restart_done c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  task automatic test_restart_run();
    exp_t e, got;
    for (int c = 1; c <= 31; c++) begin
      start = (c == 27);
      sb.push_back((c <= 26) ? exp_run(c) : exp_run(c - 27));
      step();
      start = 1'b0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL restart_run c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  task automatic test_priority_start_pause();
    exp_t e, got;
    for (int c = 0; c <= 5; c++) begin
      start     = (c == 0);
      pause_tgl = (c == 0);
      sb.push_back(exp_run(c));
      step();
      {start, pause_tgl} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL prio_start_pause c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  task automatic test_pause();
    exp_t e, got;
    for (int c = 0; c <= 38; c++) begin
      start     = (c == 0);
      pause_tgl = (c == 15) || (c == 36);
      if (c <= 14)      e = exp_run(c);
      else if (c <= 35) e = mk(7, 0, 0, 0, 0);
      else if (c == 36) e = mk(7, 1, 0, 0, 0);
      else if (c == 37) e = mk(6, 1, 0, 0, 1);
      else              e = mk(6, 1, 0, 0, 0);
      sb.push_back(e);
      step();
      {start, pause_tgl} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL pause c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e, got;
    for (int c = 0; c <= 25; c++) begin
      start    = (c == 0);
      add_time = (c == 5) || (c == 25);
      if (c <= 4)       e = exp_run(c);
      else if (c == 5)  e = mk(10, 1, 0, 0, 0);
      else if (c <= 24) e = exp_run(c - 4);
      else              e = mk(8, 1, 0, 0, 0);
      sb.push_back(e);
      step();
      {start, add_time} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL saturation c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  task automatic test_add_on_tick();
    exp_t e, got;
    for (int c = 0; c <= 44; c++) begin
      start    = (c == 0);
      add_time = (c == 40);
      if (c <= 39)      e = exp_run(c);
      else if (c == 40) e = mk(3, 1, 0, 0, 1);
      else if (c <= 43) e = mk(3, 1, 0, 0, 0);
      else              e = mk(2, 1, 0, 0, 1);
      sb.push_back(e);
      step();
      {start, add_time} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL add_on_tick c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  task automatic test_pause_on_expire();
    exp_t e, got;
    for (int c = 0; c <= 43; c++) begin
      start     = (c == 0);
      pause_tgl = (c == 40) || (c == 42);
      sb.push_back(exp_run(c));
      step();
      {start, pause_tgl} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL pause_on_expire c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, got;
    for (int c = 0; c <= 26; c++) begin
      start     = (c == 0);
      pause_tgl = (c == 17) || (c == 20);
      rst       = (c == 18);
      add_time  = (c == 18) || (c == 19);
      if (c <= 16)      e = exp_run(c);
      else if (c == 17) e = mk(6, 0, 0, 0, 0);
      else              e = mk(10, 0, 0, 0, 0);
      sb.push_back(e);
      step();
      {start, pause_tgl, rst, add_time} = '0;
      got = outs();
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_mid c=%0d got=%b want=%b", c, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_restart_done();
    test_restart_run();
    test_priority_start_pause();
    test_pause();
    test_saturation();
    test_add_on_tick();
    test_pause_on_expire();
    test_reset_mid();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
